// File: rtl/uart_tx_queue_if.sv
// Producer/uart-side signal bundle for uart_tx_queue.
// drop_count exists only when UART_TX_QUEUE_DROP_COUNT_EN is defined.
interface uart_tx_queue_if #(
   parameter int unsigned DEPTH_LOG2 = 4
);
   logic                  wr_en;
   logic [7:0]            wr_data;
   logic                  full;
   logic                  empty;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;
   logic                  clr_overflow;
   logic                  uart_transmit;
   logic [7:0]            uart_tx_byte;
   logic                  uart_busy;
   logic                  busy;
   logic                  tx_error;
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
   logic [7:0]            drop_count;

   modport master (
      output wr_en, wr_data, clr_overflow, uart_busy,
      input  full, empty, level, overflow, uart_transmit, uart_tx_byte, busy, tx_error,
             drop_count
   );
   modport slave (
      input  wr_en, wr_data, clr_overflow, uart_busy,
      output full, empty, level, overflow, uart_transmit, uart_tx_byte, busy, tx_error,
             drop_count
   );
`else
   modport master (
      output wr_en, wr_data, clr_overflow, uart_busy,
      input  full, empty, level, overflow, uart_transmit, uart_tx_byte, busy, tx_error
   );
   modport slave (
      input  wr_en, wr_data, clr_overflow, uart_busy,
      output full, empty, level, overflow, uart_transmit, uart_tx_byte, busy, tx_error
   );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus handshake sequencer feeding a uart transmitter one byte at a time.
// Optional drop counter enabled by defining UART_TX_QUEUE_DROP_COUNT_EN.
module uart_tx_queue #(
   parameter int unsigned DEPTH_LOG2  = 4,
   parameter int unsigned GAP_CYCLES  = 0,
   parameter int unsigned ACK_TIMEOUT = 4
) (
   input logic            clk_i,
   input logic            rst_i,
   uart_tx_queue_if.slave q_if
);
   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
   localparam int unsigned AckW  = $clog2(ACK_TIMEOUT + 2);
   localparam int unsigned GapW  = $clog2(GAP_CYCLES + 2);

   typedef enum logic [2:0] {QIdle, QStart, QWaitAck, QWaitDone, QGap} state_e;

   logic [7:0]      mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] level;
   logic            full, empty;
   logic            push_ok, push_rej, pop;

   state_e          state_q, state_d;
   logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
   logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
   logic            overflow_q, overflow_d;
   logic            tx_error_q, tx_error_d;
   logic            transmit_q, transmit_d;
   logic [7:0]      tx_byte_q, tx_byte_d;

   // Extra pointer MSB lets the plain difference reach Depth when full.
   assign level    = wr_ptr_q - rd_ptr_q;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (level == PtrW'(Depth));
   assign push_ok  = q_if.wr_en && !full;
   assign push_rej = q_if.wr_en && full;
   assign pop      = (state_q == QIdle) && !empty && !q_if.uart_busy;

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[PtrW-2:0]] <= q_if.wr_data;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      state_d    = state_q;
      ack_cnt_d  = ack_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      overflow_d = overflow_q;
      tx_error_d = tx_error_q;
      transmit_d = 1'b0;
      tx_byte_d  = tx_byte_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      // A rejected push outranks a clear in the same cycle.
      if (push_rej) begin
         overflow_d = 1'b1;
      end else if (q_if.clr_overflow) begin
         overflow_d = 1'b0;
      end

      unique case (state_q)
         QIdle: begin
            if (pop) begin
               rd_ptr_d   = rd_ptr_q + PtrW'(1);
               tx_byte_d  = mem_q[rd_ptr_q[PtrW-2:0]];
               transmit_d = 1'b1;
               state_d    = QStart;
            end
         end
         QStart: begin
            ack_cnt_d = AckW'(ACK_TIMEOUT);
            state_d   = QWaitAck;
         end
         QWaitAck: begin
            if (q_if.uart_busy) begin
               state_d = QWaitDone;
            end else if (ack_cnt_q == '0) begin
               tx_error_d = 1'b1;
               state_d    = QIdle;
            end else begin
               ack_cnt_d = ack_cnt_q - AckW'(1);
            end
         end
         QWaitDone: begin
            if (!q_if.uart_busy) begin
               if (GAP_CYCLES > 0) begin
                  gap_cnt_d = GapW'(GAP_CYCLES - 1);
                  state_d   = QGap;
               end else begin
                  state_d = QIdle;
               end
            end
         end
         QGap: begin
            if (gap_cnt_q == '0) begin
               state_d = QIdle;
            end else begin
               gap_cnt_d = gap_cnt_q - GapW'(1);
            end
         end
         default: state_d = QIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         state_q    <= QIdle;
         ack_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         overflow_q <= 1'b0;
         tx_error_q <= 1'b0;
         transmit_q <= 1'b0;
         tx_byte_q  <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         state_q    <= state_d;
         ack_cnt_q  <= ack_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         overflow_q <= overflow_d;
         tx_error_q <= tx_error_d;
         transmit_q <= transmit_d;
         tx_byte_q  <= tx_byte_d;
      end
   end

`ifdef UART_TX_QUEUE_DROP_COUNT_EN
   logic [7:0] drop_count_q, drop_count_d;

   always_comb begin
      drop_count_d = drop_count_q;
      if (push_rej) begin
         if (q_if.clr_overflow) begin
            drop_count_d = 8'd1;
         end else if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
         end
      end else if (q_if.clr_overflow) begin
         drop_count_d = 8'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_count_q <= 8'd0;
      end else begin
         drop_count_q <= drop_count_d;
      end
   end

   assign q_if.drop_count = drop_count_q;
`endif

   assign q_if.full          = full;
   assign q_if.empty         = empty;
   assign q_if.level         = level;
   assign q_if.overflow      = overflow_q;
   assign q_if.uart_transmit = transmit_q;
   assign q_if.uart_tx_byte  = tx_byte_q;
   assign q_if.busy          = !empty || (state_q != QIdle);
   assign q_if.tx_error      = tx_error_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a uart stand-in answers transmit pulses and
// records the byte stream, which is compared against queues of the bytes pushed.
module tb_uart_tx_queue;
   localparam int unsigned DepthLog2 = 4;
   localparam int unsigned Depth     = 16;
   localparam int unsigned Gap       = 2;
   localparam int unsigned AckTo     = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_queue_if #(.DEPTH_LOG2(DepthLog2)) qif ();

   uart_tx_queue #(
      .DEPTH_LOG2 (DepthLog2),
      .GAP_CYCLES (Gap),
      .ACK_TIMEOUT(AckTo)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .q_if (qif)
   );

   int         total = 0;
   int         bad = 0;
   logic [7:0] rx_q[$];
   bit         model_en = 1'b1;
   bit         stuck = 1'b0;
   bit         artificial = 1'b0;
   int         dur_min = 2;
   int         dur_max = 6;
   int         busy_cnt = 0;
   int         idle_run = 1000;
   logic       prev_tx = 1'b0;

   // uart stand-in plus pulse-shape monitor, all on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         qif.uart_busy = 1'b0;
         busy_cnt = 0;
         idle_run = 1000;
         prev_tx = 1'b0;
         artificial = 1'b0;
      end else begin
         if (qif.uart_transmit === 1'b1) begin
            total++;
            if (prev_tx) begin
               bad++;
               $display("FAIL pulse_width: uart_transmit high 2+ cycles, required 1");
            end
            total++;
            if (qif.uart_busy) begin
               bad++;
               $display("FAIL pulse_while_busy: transmit seen with uart_busy=1, required 0");
            end
            total++;
            if (idle_run < int'(Gap) + 2) begin
               bad++;
               $display("FAIL pulse_gap: idle cycles before pulse=%0d required>=%0d",
                        idle_run, Gap + 2);
            end
         end
         prev_tx = (qif.uart_transmit === 1'b1);
         if (qif.uart_transmit === 1'b1 && model_en) begin
            rx_q.push_back(qif.uart_tx_byte);
            qif.uart_busy = 1'b1;
            artificial = 1'b0;
            busy_cnt = $urandom_range(dur_max, dur_min);
         end else if (stuck) begin
            qif.uart_busy = 1'b1;
            artificial = 1'b1;
         end else if (qif.uart_busy) begin
            if (busy_cnt <= 1) begin
               qif.uart_busy = 1'b0;
               busy_cnt = 0;
            end else begin
               busy_cnt--;
            end
         end
         if (qif.uart_busy && !artificial) idle_run = 0;
         else if (!qif.uart_busy && idle_run < 1000) idle_run++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 1000 && !done; i++) begin
         step();
         if (!qif.busy && !qif.uart_busy) done = 1'b1;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL wait_idle: busy still %0b after 1000 cycles, required 0", qif.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      total++; if (qif.empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %0b required 1", qif.empty); end
      total++; if (qif.full !== 1'b0) begin bad++; $display("FAIL rst_full: got %0b required 0", qif.full); end
      total++; if (qif.level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d required 0", qif.level); end
      total++; if (qif.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %0b required 0", qif.overflow); end
      total++; if (qif.tx_error !== 1'b0) begin bad++; $display("FAIL rst_tx_error: got %0b required 0", qif.tx_error); end
      total++; if (qif.uart_transmit !== 1'b0) begin bad++; $display("FAIL rst_transmit: got %0b required 0", qif.uart_transmit); end
      total++; if (qif.uart_tx_byte !== 8'h00) begin bad++; $display("FAIL rst_tx_byte: got %0h required 00", qif.uart_tx_byte); end
      total++; if (qif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b required 0", qif.busy); end
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
      total++; if (qif.drop_count !== 8'd0) begin bad++; $display("FAIL rst_drop_count: got %0d required 0", qif.drop_count); end
`endif
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      rx_q.delete();
      qif.wr_en = 1'b1;
      qif.wr_data = 8'hA5;
      step();
      qif.wr_en = 1'b0;
      total++; if (qif.empty !== 1'b0) begin bad++; $display("FAIL single_empty: got %0b required 0", qif.empty); end
      total++; if (qif.level !== 5'd1) begin bad++; $display("FAIL single_level1: got %0d required 1", qif.level); end
      total++; if (qif.uart_transmit !== 1'b0) begin bad++; $display("FAIL single_early: got %0b required 0", qif.uart_transmit); end
      step();
      total++; if (qif.uart_transmit !== 1'b1) begin bad++; $display("FAIL single_pulse: got %0b required 1", qif.uart_transmit); end
      total++; if (qif.uart_tx_byte !== 8'hA5) begin bad++; $display("FAIL single_byte: got %0h required a5", qif.uart_tx_byte); end
      total++; if (qif.level !== 5'd0) begin bad++; $display("FAIL single_level0: got %0d required 0", qif.level); end
      step();
      total++; if (qif.uart_transmit !== 1'b0) begin bad++; $display("FAIL single_pulse_end: got %0b required 0", qif.uart_transmit); end
      wait_idle();
      total++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
         bad++;
         $display("FAIL single_stream: got %0d bytes required 1 byte a5", rx_q.size());
      end
   endtask

   task automatic test_burst();
      logic exp_full;
      rx_q.delete();
      stuck = 1'b1;
      repeat (2) step();
      for (int i = 0; i < int'(Depth); i++) begin
         qif.wr_en = 1'b1;
         qif.wr_data = 8'(i + 1);
         step();
         exp_full = (i == int'(Depth) - 1);
         total++; if (qif.level !== 5'(i + 1)) begin bad++; $display("FAIL burst_level: got %0d required %0d", qif.level, i + 1); end
         total++; if (qif.full !== exp_full) begin bad++; $display("FAIL burst_full: got %0b required %0b", qif.full, exp_full); end
      end
      qif.wr_en = 1'b0;
      stuck = 1'b0;
      wait_idle();
      total++;
      if (rx_q.size() != int'(Depth)) begin
         bad++;
         $display("FAIL burst_count: got %0d bytes required %0d", rx_q.size(), Depth);
      end
      for (int i = 0; i < rx_q.size() && i < int'(Depth); i++) begin
         total++;
         if (rx_q[i] !== 8'(i + 1)) begin
            bad++;
            $display("FAIL burst_order: byte %0d got %0h required %0h", i, rx_q[i], i + 1);
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      rx_q.delete();
      stuck = 1'b1;
      repeat (2) step();
      for (int i = 0; i < int'(Depth); i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         qif.wr_en = 1'b1;
         qif.wr_data = b;
         step();
      end
      total++; if (qif.overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %0b required 0", qif.overflow); end
      qif.wr_data = 8'hFF;
      step();
      total++; if (qif.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0b required 1", qif.overflow); end
      total++; if (qif.level !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d required 16", qif.level); end
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
      total++; if (qif.drop_count !== 8'd1) begin bad++; $display("FAIL ovf_drop1: got %0d required 1", qif.drop_count); end
`endif
      qif.wr_data = 8'h77;
      qif.clr_overflow = 1'b1;
      step();
      total++; if (qif.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %0b required 1", qif.overflow); end
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
      total++; if (qif.drop_count !== 8'd1) begin bad++; $display("FAIL ovf_drop_clr: got %0d required 1", qif.drop_count); end
`endif
      qif.wr_en = 1'b0;
      step();
      total++; if (qif.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0b required 0", qif.overflow); end
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
      total++; if (qif.drop_count !== 8'd0) begin bad++; $display("FAIL ovf_drop_zero: got %0d required 0", qif.drop_count); end
`endif
      qif.clr_overflow = 1'b0;
      stuck = 1'b0;
      wait_idle();
      total++;
      if (rx_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL ovf_count: got %0d bytes required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (rx_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL ovf_order: byte %0d got %0h required %0h", i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int t_pulse = -1;
      int t_err = -1;
      model_en = 1'b0;
      total++; if (qif.tx_error !== 1'b0) begin bad++; $display("FAIL to_pre: got %0b required 0", qif.tx_error); end
      qif.wr_en = 1'b1;
      qif.wr_data = 8'h3C;
      for (int k = 0; k < 30; k++) begin
         step();
         qif.wr_en = 1'b0;
         if (qif.uart_transmit === 1'b1 && t_pulse < 0) t_pulse = k;
         if (qif.tx_error === 1'b1 && t_err < 0) t_err = k;
      end
      total++;
      if (t_pulse < 0 || t_err < 0 || t_err - t_pulse < int'(AckTo) + 1 ||
          t_err - t_pulse > int'(AckTo) + 3) begin
         bad++;
         $display("FAIL to_delay: pulse at %0d error at %0d, required gap %0d..%0d",
                  t_pulse, t_err, AckTo + 1, AckTo + 3);
      end
      total++; if (qif.busy !== 1'b0) begin bad++; $display("FAIL to_idle: got busy=%0b required 0", qif.busy); end
      model_en = 1'b1;
      rx_q.delete();
      qif.wr_en = 1'b1;
      qif.wr_data = 8'h5A;
      step();
      qif.wr_en = 1'b0;
      wait_idle();
      total++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
         bad++;
         $display("FAIL to_next_byte: got %0d bytes required 1 byte 5a", rx_q.size());
      end
      total++; if (qif.tx_error !== 1'b1) begin bad++; $display("FAIL to_sticky: got %0b required 1", qif.tx_error); end
   endtask

   task automatic test_reset_mid();
      dur_min = 60;
      dur_max = 60;
      rx_q.delete();
      for (int i = 0; i < 6; i++) begin
         qif.wr_en = 1'b1;
         qif.wr_data = 8'(8'h40 + i);
         step();
      end
      qif.wr_en = 1'b0;
      repeat (3) step();
      total++; if (qif.level !== 5'd5) begin bad++; $display("FAIL mid_level5: got %0d required 5", qif.level); end
      total++; if (qif.uart_busy !== 1'b1) begin bad++; $display("FAIL mid_uart_busy: got %0b required 1", qif.uart_busy); end
      rst = 1'b1;
      step();
      total++; if (qif.empty !== 1'b1) begin bad++; $display("FAIL mid_empty: got %0b required 1", qif.empty); end
      total++; if (qif.level !== 5'd0) begin bad++; $display("FAIL mid_level0: got %0d required 0", qif.level); end
      total++; if (qif.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b required 0", qif.busy); end
      total++; if (qif.uart_transmit !== 1'b0) begin bad++; $display("FAIL mid_transmit: got %0b required 0", qif.uart_transmit); end
      total++; if (qif.tx_error !== 1'b0) begin bad++; $display("FAIL mid_tx_error: got %0b required 0", qif.tx_error); end
      rst = 1'b0;
      dur_min = 2;
      dur_max = 6;
      step();
   endtask

   task automatic test_wrap();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int pushed = 0;
      int guard = 0;
      rx_q.delete();
      while (pushed < 40 && guard < 3000) begin
         if (!qif.full && $urandom_range(1, 0) == 1) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            qif.wr_en = 1'b1;
            qif.wr_data = b;
            pushed++;
         end else begin
            qif.wr_en = 1'b0;
         end
         step();
         guard++;
         total++;
         if (int'(qif.level) != pushed - rx_q.size()) begin
            bad++;
            $display("FAIL wrap_level: got %0d required %0d", qif.level, pushed - rx_q.size());
         end
      end
      qif.wr_en = 1'b0;
      wait_idle();
      total++;
      if (rx_q.size() != 40) begin
         bad++;
         $display("FAIL wrap_count: got %0d bytes required 40", rx_q.size());
      end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (rx_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL wrap_order: byte %0d got %0h required %0h", i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      qif.wr_en = 1'b0;
      qif.wr_data = 8'h00;
      qif.clr_overflow = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_timeout();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
